joystick_conditioner: RTL and testbench

Conditions the two raw DB9 joystick ports (FA_*/FB_*) before they reach the mainboard `joy1`/`joy2` inputs. It provides:

- synchronization into `clk` and per-bit debouncing of the active-low switches;
- opposing-direction cancellation;
- optional per-port autofire on the fire button.

It replaces the direct inversion currently feeding the mainboard and runs entirely in the system clock domain.

---
 rtl/joystick_conditioner.sv | 185 ++++++++++++++++++
 tb/tb_joystick_conditioner.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_conditioner.sv
// joystick_conditioner: two DB9 ports -> sync, per-bit debounce, opposing
// direction cancellation, optional autofire (JOYSTICK_AUTOFIRE_EN), and
// registered active-high outputs with a change pulse.
// Bit order on every 5-bit vector: [0]=fire [1]=left [2]=right [3]=down [4]=up.

module joy_debounce_bit #(
  parameter int DEBOUNCE_MS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_press,
  output logic o_stable
);
  localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // count ticks while the level disagrees with the accepted state; any agreement restarts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (i_press == r_stable) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (r_cnt == CW'(DEBOUNCE_MS - 1)) begin
        r_stable <= i_press;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
endmodule

module joy_port #(
  parameter int AUTOFIRE_HALF_MS = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_af_en,
  input  logic [0:4] i_stable,
  output logic [0:4] o_val
);
  logic w_fire;

`ifdef JOYSTICK_AUTOFIRE_EN
  localparam int AW = (AUTOFIRE_HALF_MS > 1) ? $clog2(AUTOFIRE_HALF_MS) : 1;

  logic [AW-1:0] r_af_cnt;
  logic          r_phase;
  logic          r_fire_d;
  logic          w_rise;

  // first cycle of a new press: output high now, phase restarts from 1
  assign w_rise = i_stable[0] & ~r_fire_d;

  // phase toggles every half-period of ticks while fire is held, enabled or not
  always_ff @(posedge clk) begin
    if (reset) begin
      r_af_cnt <= '0;
      r_phase  <= 1'b0;
      r_fire_d <= 1'b0;
    end else begin
      r_fire_d <= i_stable[0];
      if (w_rise) begin
        r_phase  <= 1'b1;
        r_af_cnt <= '0;
      end else if (i_stable[0] && i_tick) begin
        if (r_af_cnt == AW'(AUTOFIRE_HALF_MS - 1)) begin
          r_phase  <= ~r_phase;
          r_af_cnt <= '0;
        end else begin
          r_af_cnt <= r_af_cnt + 1'b1;
        end
      end
    end
  end

  assign w_fire = i_stable[0] & (~i_af_en | w_rise | r_phase);
`else
  logic w_unused;
  assign w_unused = ^{clk, reset, i_tick, i_af_en};
  assign w_fire   = i_stable[0];
`endif

  // opposing directions pressed together cancel each other; fire passes
  always_comb begin
    o_val    = '0;
    o_val[0] = w_fire;
    o_val[1] = i_stable[1] & ~i_stable[2];
    o_val[2] = i_stable[2] & ~i_stable[1];
    o_val[3] = i_stable[3] & ~i_stable[4];
    o_val[4] = i_stable[4] & ~i_stable[3];
  end
endmodule

module joystick_conditioner #(
  parameter int CLK_HZ           = 107386350,
  parameter int DEBOUNCE_MS      = 5,
  parameter int AUTOFIRE_HALF_MS = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:4] joya_n,
  input  logic [0:4] joyb_n,
  input  logic       autofire_a,
  input  logic       autofire_b,
  output logic [0:4] joy1,
  output logic [0:4] joy2,
  output logic       joy_change
);
  localparam int P  = CLK_HZ / 1000;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  // index 0 = port A, 1 = port B
  logic [1:0][0:4] r_sync1, r_sync2, w_stable, w_val;
  logic [1:0]      w_af;
  logic [PW-1:0]   r_presc;
  logic            w_tick;
  logic [0:4]      r_joy1, r_joy2;
  logic            r_change;

  assign w_af   = {autofire_b, autofire_a};
  assign w_tick = (r_presc == PW'(P - 1));

  // 1 ms tick prescaler
  always_ff @(posedge clk) begin
    if (reset || w_tick) r_presc <= '0;
    else                 r_presc <= r_presc + 1'b1;
  end

  // two-flop synchronizer, released (high) after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {joyb_n, joya_n};
      r_sync2 <= r_sync1;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    for (genvar b = 0; b < 5; b++) begin : g_bit
      joy_debounce_bit #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
        .clk      (clk),
        .reset    (reset),
        .i_tick   (w_tick),
        .i_press  (~r_sync2[p][b]),
        .o_stable (w_stable[p][b])
      );
    end
    joy_port #(.AUTOFIRE_HALF_MS(AUTOFIRE_HALF_MS)) u_port (
      .clk      (clk),
      .reset    (reset),
      .i_tick   (w_tick),
      .i_af_en  (w_af[p]),
      .i_stable (w_stable[p]),
      .o_val    (w_val[p])
    );
  end

  // output registers; change pulse lines up with the new value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_joy1   <= '0;
      r_joy2   <= '0;
      r_change <= 1'b0;
    end else begin
      r_joy1   <= w_val[0];
      r_joy2   <= w_val[1];
      r_change <= (w_val[0] != r_joy1) || (w_val[1] != r_joy2);
    end
  end

  assign joy1       = r_joy1;
  assign joy2       = r_joy2;
  assign joy_change = r_change;
endmodule

// File: tb/tb_joystick_conditioner.sv
// Scoreboard bench for joystick_conditioner (P=10 cycles, 3 ms debounce,
// autofire half-period 2 ticks). Expected outputs are queued when stimulus
// is driven and popped on each joy_change pulse.
// Latency from a raw edge (driven on a falling clock edge) to the negedge
// where the new output is visible: 2 sync + 21..30 debounce + 1 output
// stage + 1 for the first posedge = 24..33 rising edges.

module tb_joystick_conditioner;
  localparam int LO = 24;
  localparam int HI = 33;

  typedef struct packed {
    logic [0:4] j1;
    logic [0:4] j2;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:4] joya_n, joyb_n, joy1, joy2;
  logic       autofire_a, autofire_b, joy_change;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pulses = 0;

  joystick_conditioner #(.CLK_HZ(10000), .DEBOUNCE_MS(3), .AUTOFIRE_HALF_MS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .joya_n     (joya_n),
    .joyb_n     (joyb_n),
    .autofire_a (autofire_a),
    .autofire_b (autofire_b),
    .joy1       (joy1),
    .joy2       (joy2),
    .joy_change (joy_change)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (joy_change === 1'b1) pulses <= pulses + 1;

  function automatic exp_t mk(input logic [0:4] a, input logic [0:4] b);
    exp_t e;
    e.j1 = a;
    e.j2 = b;
    return e;
  endfunction

  // wait for the next change pulse (bounded), pop the matching expectation
  task automatic observe(input int t0, input int limit, output bit seen,
                         output int lat, output exp_t e);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (joy_change === 1'b1) seen = 1'b1;
    end
    lat = cyc - t0;
    e   = q_exp.pop_front();
  endtask

  task automatic test_reset();
    bit seen; int t0, lat, p0; exp_t e;
    reset = 1'b1; joya_n = 5'b00000; joyb_n = 5'b11111;
    autofire_a = 1'b0; autofire_b = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (joy1 !== 5'b0 || joy2 !== 5'b0 || joy_change !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: joy1=%b joy2=%b chg=%b want 0 0 0", joy1, joy2, joy_change);
    end
    // everything held through reset: both direction pairs cancel, only fire shows
    q_exp.push_back(mk(5'b10000, 5'b00000));
    p0 = pulses;
    reset = 1'b0; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat != 31) begin
      errors++; $display("FAIL reset_lat: seen=%0d lat=%0d want 31", seen, lat);
    end
    checks++;
    if (joy1 !== e.j1 || joy2 !== e.j2) begin
      errors++; $display("FAIL reset_val: joy1=%b joy2=%b want %b %b", joy1, joy2, e.j1, e.j2);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (pulses != p0 + 1) begin
      errors++; $display("FAIL reset_pulses: got %0d want 1", pulses - p0);
    end
    q_exp.push_back(mk(5'b00000, 5'b00000));
    joya_n = 5'b11111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1 || joy2 !== e.j2) begin
      errors++;
      $display("FAIL reset_release: seen=%0d lat=%0d joy1=%b want lat %0d..%0d joy1 %b", seen, lat, joy1, LO, HI, e.j1);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_press();
    bit seen; int t0, lat, p0; exp_t e;
    p0 = pulses;
    q_exp.push_back(mk(5'b00000, 5'b10000));
    joyb_n = 5'b01111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI) begin
      errors++; $display("FAIL press_lat: seen=%0d lat=%0d want %0d..%0d", seen, lat, LO, HI);
    end
    checks++;
    if (joy1 !== e.j1 || joy2 !== e.j2) begin
      errors++; $display("FAIL press_val: joy1=%b joy2=%b want %b %b", joy1, joy2, e.j1, e.j2);
    end
    repeat (5) @(negedge clk);
    q_exp.push_back(mk(5'b00000, 5'b00000));
    joyb_n = 5'b11111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1 || joy2 !== e.j2) begin
      errors++;
      $display("FAIL release_b: seen=%0d lat=%0d joy2=%b want lat %0d..%0d joy2 %b", seen, lat, joy2, LO, HI, e.j2);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (pulses != p0 + 2) begin
      errors++; $display("FAIL press_pulses: got %0d want 2", pulses - p0);
    end
  endtask

  task automatic test_bounce();
    bit seen; int t0, lat, p0; exp_t e;
    p0 = pulses;
    joya_n = 5'b11110; repeat (15) @(negedge clk);
    joya_n = 5'b11111; repeat (5)  @(negedge clk);
    checks++;
    if (pulses != p0 || joy1 !== 5'b00000) begin
      errors++; $display("FAIL bounce_early: pulses=%0d joy1=%b want 0 00000", pulses - p0, joy1);
    end
    q_exp.push_back(mk(5'b00001, 5'b00000));
    joya_n = 5'b11110; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1 || joy2 !== e.j2) begin
      errors++;
      $display("FAIL bounce_accept: seen=%0d lat=%0d joy1=%b want lat %0d..%0d joy1 %b", seen, lat, joy1, LO, HI, e.j1);
    end
    q_exp.push_back(mk(5'b00000, 5'b00000));
    joya_n = 5'b11111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || joy1 !== e.j1) begin
      errors++; $display("FAIL bounce_release: seen=%0d joy1=%b want %b", seen, joy1, e.j1);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_cancel();
    bit seen; int t0, lat, p0; exp_t e;
    p0 = pulses;
    joya_n = 5'b10011;   // left + right
    joyb_n = 5'b11100;   // down + up
    repeat (45) @(negedge clk);
    checks++;
    if (pulses != p0 || joy1 !== 5'b00000 || joy2 !== 5'b00000) begin
      errors++;
      $display("FAIL cancel_hold: pulses=%0d joy1=%b joy2=%b want 0 00000 00000", pulses - p0, joy1, joy2);
    end
    q_exp.push_back(mk(5'b01000, 5'b00010));
    joya_n = 5'b10111;   // right released, left remains
    joyb_n = 5'b11101;   // up released, down remains
    t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1 || joy2 !== e.j2) begin
      errors++;
      $display("FAIL cancel_release: seen=%0d lat=%0d joy1=%b joy2=%b want %b %b", seen, lat, joy1, joy2, e.j1, e.j2);
    end
    q_exp.push_back(mk(5'b00000, 5'b00000));
    joya_n = 5'b11111; joyb_n = 5'b11111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || joy1 !== e.j1 || joy2 !== e.j2) begin
      errors++; $display("FAIL cancel_clear: seen=%0d joy1=%b joy2=%b want 0 0", seen, joy1, joy2);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit seen; int t0, lat; exp_t e;
    q_exp.push_back(mk(5'b10000, 5'b00100));
    joya_n = 5'b01111; joyb_n = 5'b11011; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1 || joy2 !== e.j2) begin
      errors++;
      $display("FAIL b2b_both: seen=%0d lat=%0d joy1=%b joy2=%b want %b %b", seen, lat, joy1, joy2, e.j1, e.j2);
    end
    q_exp.push_back(mk(5'b00000, 5'b00100));
    joya_n = 5'b11111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1 || joy2 !== e.j2) begin
      errors++;
      $display("FAIL b2b_next: seen=%0d lat=%0d joy1=%b joy2=%b want %b %b", seen, lat, joy1, joy2, e.j1, e.j2);
    end
    q_exp.push_back(mk(5'b00000, 5'b00000));
    joyb_n = 5'b11111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || joy2 !== e.j2) begin
      errors++; $display("FAIL b2b_clear: seen=%0d joy2=%b want %b", seen, joy2, e.j2);
    end
    repeat (40) @(negedge clk);
  endtask

`ifdef JOYSTICK_AUTOFIRE_EN
  task automatic test_autofire();
    bit seen; int t0, lat, p0; exp_t e;
    int t_prev;
    autofire_a = 1'b1;
    q_exp.push_back(mk(5'b10000, 5'b00000));
    joya_n = 5'b01111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1) begin
      errors++; $display("FAIL af_press: seen=%0d lat=%0d joy1=%b want %b", seen, lat, joy1, e.j1);
    end
    // 20 cycles high, 20 low, 20 high, then low
    for (int k = 0; k < 3; k++) begin
      t_prev = cyc;
      q_exp.push_back(mk((k % 2 == 0) ? 5'b00000 : 5'b10000, 5'b00000));
      observe(t_prev, 25, seen, lat, e);
      checks++;
      if (!seen || lat != 20 || joy1 !== e.j1) begin
        errors++; $display("FAIL af_period%0d: seen=%0d lat=%0d joy1=%b want 20 %b", k, seen, lat, joy1, e.j1);
      end
    end
    // now in a low phase that just started: disabling shows steady fire next cycle
    t_prev = cyc;
    autofire_a = 1'b0;
    q_exp.push_back(mk(5'b10000, 5'b00000));
    observe(t_prev, 5, seen, lat, e);
    checks++;
    if (!seen || lat != 1 || joy1 !== e.j1) begin
      errors++; $display("FAIL af_disable: seen=%0d lat=%0d joy1=%b want 1 %b", seen, lat, joy1, e.j1);
    end
    // re-enable mid low phase: phase resumes, counter was not cleared
    repeat (4) @(negedge clk);
    autofire_a = 1'b1;
    q_exp.push_back(mk(5'b00000, 5'b00000));
    observe(t_prev, 5, seen, lat, e);
    checks++;
    if (!seen || lat != 6 || joy1 !== e.j1) begin
      errors++; $display("FAIL af_reenable: seen=%0d lat=%0d joy1=%b want 6 %b", seen, lat, joy1, e.j1);
    end
    q_exp.push_back(mk(5'b10000, 5'b00000));
    observe(t_prev, 20, seen, lat, e);
    checks++;
    if (!seen || lat != 20 || joy1 !== e.j1) begin
      errors++; $display("FAIL af_resume: seen=%0d lat=%0d joy1=%b want 20 %b", seen, lat, joy1, e.j1);
    end
    autofire_a = 1'b0;
    @(negedge clk);
    p0 = pulses;
    repeat (45) @(negedge clk);
    checks++;
    if (pulses != p0 || joy1 !== 5'b10000) begin
      errors++; $display("FAIL af_steady: pulses=%0d joy1=%b want 0 10000", pulses - p0, joy1);
    end
    q_exp.push_back(mk(5'b00000, 5'b00000));
    joya_n = 5'b11111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1) begin
      errors++; $display("FAIL af_release: seen=%0d lat=%0d joy1=%b want %b", seen, lat, joy1, e.j1);
    end
    repeat (20) @(negedge clk);
  endtask
`else
  task automatic test_autofire();
    bit seen; int t0, lat, p0; exp_t e;
    autofire_a = 1'b1;
    q_exp.push_back(mk(5'b10000, 5'b00000));
    joya_n = 5'b01111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1) begin
      errors++; $display("FAIL af_press: seen=%0d lat=%0d joy1=%b want %b", seen, lat, joy1, e.j1);
    end
    @(negedge clk);
    p0 = pulses;
    repeat (60) @(negedge clk);
    autofire_a = 1'b0;
    repeat (10) @(negedge clk);
    autofire_a = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (pulses != p0 || joy1 !== 5'b10000) begin
      errors++; $display("FAIL af_off_steady: pulses=%0d joy1=%b want 0 10000", pulses - p0, joy1);
    end
    q_exp.push_back(mk(5'b00000, 5'b00000));
    joya_n = 5'b11111; t0 = cyc;
    observe(t0, 45, seen, lat, e);
    checks++;
    if (!seen || lat < LO || lat > HI || joy1 !== e.j1) begin
      errors++; $display("FAIL af_release: seen=%0d lat=%0d joy1=%b want %b", seen, lat, joy1, e.j1);
    end
    repeat (20) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_cancel();
    test_back_to_back();
    test_autofire();
    checks++;
    if (q_exp.size() != 0) begin
      errors++; $display("FAIL scoreboard_left: %0d entries remain want 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end
endmodule
